// File: rtl/demux_pkg.sv
// Shared types and constants for the demux8_capture serial-to-parallel block.
// Optional feature macro used by the design: DEMUX_PARITY_EN (adds a parity bit after each word).
package demux_pkg;

  // Default number of output lanes.
  localparam int unsigned DefaultWidth = 8;

  // Even parity: XOR over data bits plus parity bit must equal this value.
  localparam logic ParityEven = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StParity
  } state_e;

endpackage

// File: rtl/demux8_capture_if.sv
// Bundle of the serial-capture data/control signals and the captured outputs.
// master: the serial source (drives din/din_valid/addr_mode/s/clr, observes outputs).
// slave : the demux8_capture block.
// par_err exists only when DEMUX_PARITY_EN is defined.
interface demux8_capture_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SEL_W = $clog2(WIDTH)
);
  logic             din;
  logic             din_valid;
  logic             addr_mode;
  logic [SEL_W-1:0] s;
  logic             clr;
  logic [WIDTH-1:0] y;
  logic [SEL_W-1:0] slot;
  logic             done;
  logic             busy;
`ifdef DEMUX_PARITY_EN
  logic             par_err;
`endif

  modport master (
    output din, din_valid, addr_mode, s, clr,
    input  y, slot, done, busy
`ifdef DEMUX_PARITY_EN
    , input par_err
`endif
  );

  modport slave (
    input  din, din_valid, addr_mode, s, clr,
    output y, slot, done, busy
`ifdef DEMUX_PARITY_EN
    , output par_err
`endif
  );
endinterface

// File: rtl/demux8_capture_slot_counter.sv
// slot_counter: Width-bit wrap-around counter with synchronous clear and enable.
// Ports: clk, rst (sync active-high), clr_i (sync clear), en_i (advance), cnt_o (count).
module slot_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);
  logic [Width-1:0] cnt_d, cnt_q;

  // Natural binary overflow gives the wrap from WIDTH-1 back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/demux8_capture.sv
// demux8_capture: captures a serial bit stream (bit 0 first) into a WIDTH-bit parallel word.
// Ports: clk, rst (sync active-high), bus (demux8_capture_if.slave):
//   din/din_valid serial input, addr_mode/s direct lane write, clr abort,
//   y captured word, slot next lane, done word-complete pulse, busy word in progress,
//   par_err (only with DEMUX_PARITY_EN) even-parity error flag held until next done/clr/rst.
module demux8_capture
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst,
  demux8_capture_if.slave bus
);
  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(WIDTH - 1);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] y_d, y_q;
  logic             done_d, done_q;
  logic             busy_d, busy_q;
  logic             cnt_en;
  logic [SEL_W-1:0] slot;
`ifdef DEMUX_PARITY_EN
  logic             par_err_d, par_err_q;
`endif

  slot_counter #(
    .Width (SEL_W)
  ) u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (bus.clr),
    .en_i  (cnt_en),
    .cnt_o (slot)
  );

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    done_d    = 1'b0;
    cnt_en    = 1'b0;
`ifdef DEMUX_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (bus.clr) begin
      // Abort: lanes are retained, any pending done is dropped.
      state_d = StIdle;
`ifdef DEMUX_PARITY_EN
      par_err_d = 1'b0;
`endif
    end else if (bus.din_valid && bus.addr_mode) begin
      // Direct lane write; counter and state pause for this cycle.
      y_d[bus.s] = bus.din;
    end else if (bus.din_valid) begin
      case (state_q)
        StIdle, StCollect: begin
          // slot is 0 whenever the FSM is idle, so both states share this path.
          y_d[slot] = bus.din;
          cnt_en    = 1'b1;
          if (slot == LastSlot) begin
`ifdef DEMUX_PARITY_EN
            state_d = StParity;
`else
            state_d = StIdle;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = StCollect;
          end
        end
        StParity: begin
          state_d = StIdle;
          done_d  = 1'b1;
`ifdef DEMUX_PARITY_EN
          par_err_d = ((^y_q) ^ bus.din) != ParityEven;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      y_q       <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DEMUX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef DEMUX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.y    = y_q;
  assign bus.slot = slot;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
`ifdef DEMUX_PARITY_EN
  assign bus.par_err = par_err_q;
`endif
endmodule

// File: doc/demux8_capture.md
Name: demux8_capture

Overview:
- Receive-side counterpart of the structural 8:1 mux selector. The mux serialises an 8-bit word one bit per select value; this block captures that serial stream back into an 8-bit parallel word.
- Each accepted bit is demultiplexed into lane y[slot]. An internal 3-bit slot counter tracks the position, and a one-cycle done pulse fires when the word is complete.
- A direct-address mode allows writing a single lane under an external select, matching the s[2:0] usage of the mux.

Parameters:
- WIDTH, 8, number of output lanes; must be a power of 2, range 2..64.
- SEL_W, $clog2(WIDTH), width of the select and slot counter (derived; do not override).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is accepted on a cycle where it is high.
- addr_mode  input  1  1 = write din to lane s; 0 = counter-driven capture.
- s  input  SEL_W  lane select, used only when addr_mode=1.
- clr  input  1  synchronous abort of the word in progress.
- y  output  WIDTH  captured parallel word (registered).
- slot  output  SEL_W  next lane index in counter mode (registered).
- done  output  1  one-cycle pulse: word complete.
- busy  output  1  high while in COLLECT or PARITY state.
- par_err  output  1  parity error flag; present only when DEMUX_PARITY_EN is defined.

Behaviour:
- Reset: y=0, slot=0, done=0, busy=0, par_err=0, state=IDLE. Reset overrides every other input.
- Priority on each edge: rst > clr > addr_mode write > counter capture.
- States:
  - IDLE: on din_valid with addr_mode=0: y[0]<=din, slot<=1, go to COLLECT.
  - COLLECT: on din_valid: y[slot]<=din, slot<=slot+1.
    - When slot==WIDTH-1 is written: slot wraps to 0, done=1 on the next cycle, and the state returns to IDLE. With DEMUX_PARITY_EN the state goes to PARITY instead.
    - din_valid low holds state and slot indefinitely; there is no timeout.
  - PARITY (macro only): the next valid bit is the parity bit. done pulses, par_err is updated, and the state returns to IDLE.
- Latency: the last bit is accepted in cycle N; done=1 in cycle N+1 and is registered. y holds the full word from N+1 until the next write.
- Back-to-back words: a valid bit in the same cycle done=1 is accepted as bit 0 of the next word. No bubble is required.
- Lane retention: lanes not yet rewritten keep their previous value; y is not cleared between words.
- addr_mode=1 with din_valid:
  - y[s]<=din. slot, state, and done are unaffected.
  - Allowed in any state; an in-progress word pauses for that cycle.
- clr: slot<=0, state<=IDLE, done<=0, busy<=0. y is retained. A pending done in the same cycle is suppressed.
- busy = (state != IDLE), registered with the state.
- Lane ordering: the bit captured with slot=k lands in y[k], matching mux select k ↔ input k.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - A ninth serial bit follows each word and is checked for even parity over the 8 data bits plus the parity bit.
  - par_err is registered alongside done and holds until the next done, clr, or rst.
- Undefined: no PARITY state, the par_err port is absent, and done follows the last data bit.

Decomposition:
- Package demux_pkg holds:
  - the state enum (IDLE, COLLECT, PARITY),
  - the default WIDTH constant,
  - the parity polarity constant (even).
- One natural sub-module: slot_counter, a SEL_W-bit wrap counter with synchronous clear and enable.
- Lane write decode and FSM stay in the top.

Test Plan:
- Reset, then serial 1,0,0,0,0,0,0,0 (bit 0 first) with din_valid=1 continuously → done pulse on cycle 9; y=8'h01; slot=0; busy returns to 0.
- Serial 0,1,1,1,1,1,1,1 with din_valid gaps of 3 cycles after bits 2 and 5 → y=8'hFE; done fires once, exactly one cycle after the last bit.
- Two words back-to-back (8'hA5 then 8'h3C), no gap → done pulses twice, 8 cycles apart; y=8'hA5 at the first pulse and 8'h3C at the second.
- After 4 bits of a word, assert clr with din_valid=1 → slot=0 and no done. The following full word 8'hFF completes normally; y=8'hFF.
- With addr_mode=1, write s=3'b101,din=1 mid-word (slot=3) → y[5]=1 immediately; slot remains 3, and the word completes on the correct cycle.
- DEMUX_PARITY_EN: word 8'h07 followed by parity bit 1 → par_err=0. Word 8'h07 followed by parity bit 0 → par_err=1. done fires after the 9th bit in both cases.
